// File: rtl/multi_rate_counter_pkg.sv
// multi_rate_counter_pkg: digit limits and active-low seven-segment glyphs (bit order g..a)
package multi_rate_counter_pkg;
  typedef logic [3:0] digit_t;
  typedef logic [6:0] seg_t;
  localparam digit_t BCD_MAX = 4'd9;
  localparam digit_t HEX_MAX = 4'd15;
  localparam seg_t SEG_0 = 7'b1000000;
  localparam seg_t SEG_1 = 7'b1111001;
  localparam seg_t SEG_2 = 7'b0100100;
  localparam seg_t SEG_3 = 7'b0110000;
  localparam seg_t SEG_4 = 7'b0011001;
  localparam seg_t SEG_5 = 7'b0010010;
  localparam seg_t SEG_6 = 7'b0000010;
  localparam seg_t SEG_7 = 7'b1111000;
  localparam seg_t SEG_8 = 7'b0000000;
  localparam seg_t SEG_9 = 7'b0010000;
  localparam seg_t SEG_A = 7'b0001000;
  localparam seg_t SEG_B = 7'b0000011;
  localparam seg_t SEG_C = 7'b1000110;
  localparam seg_t SEG_D = 7'b0100001;
  localparam seg_t SEG_E = 7'b0000110;
  localparam seg_t SEG_F = 7'b0001110;
  localparam logic [15:0][6:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                          SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};
  function automatic digit_t digit_max(input bit decimal);
    return decimal ? BCD_MAX : HEX_MAX;
  endfunction
endpackage

// File: rtl/multi_rate_counter_hex_seg_decoder.sv
// hex_seg_decoder: one 4-bit digit to an active-low seven-segment glyph
module hex_seg_decoder
  import multi_rate_counter_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);
  assign seg = SEG_LUT[digit];
endmodule

// File: rtl/multi_rate_counter.sv
// multi_rate_counter: N-digit hex/BCD up/down counter stepped by a selectable-rate divider,
// with synchronous load, full-rollover pulse and per-digit seven-segment outputs.
module multi_rate_counter
  import multi_rate_counter_pkg::*;
#(
  parameter int                DIGITS  = 4,
  parameter bit                DECIMAL = 1'b0,
  parameter int                DIV_W   = 28,
  parameter logic [DIV_W-1:0]  RATE0   = DIV_W'(0),
  parameter logic [DIV_W-1:0]  RATE1   = DIV_W'(29999999),
  parameter logic [DIV_W-1:0]  RATE2   = DIV_W'(49999999),
  parameter logic [DIV_W-1:0]  RATE3   = DIV_W'(99999999)
) (
  input  logic                  CLOCK_50,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [1:0]            rate_sel,
  input  logic                  up_down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tick,
  output logic                  wrap,
  output logic [7*DIGITS-1:0]   HEX
);
  localparam digit_t MAX = digit_max(DECIMAL);
  logic [DIV_W-1:0] div_cnt, reload;
  logic [1:0] rate_q;
  logic rate_chg;
  logic [DIGITS:0] carry;
  logic [4*DIGITS-1:0] stepped, load_fix;
  assign reload = rate_sel == 2'd0 ? RATE0 : rate_sel == 2'd1 ? RATE1 : rate_sel == 2'd2 ? RATE2 : RATE3;
  assign rate_chg = rate_sel != rate_q;
  assign tick = enable & ~reset & (div_cnt == '0) & ~rate_chg;
  // a rate change restarts the period from the new reload so the first new tick is a full period away
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      div_cnt <= '0;
      rate_q  <= '0;
    end else begin
      rate_q <= rate_sel;
      if (enable) div_cnt <= (rate_chg || div_cnt == '0) ? reload : div_cnt - DIV_W'(1);
    end
  assign carry[0] = 1'b1;
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    logic [3:0] d;
    logic at_edge;
    assign d = count[4*i+:4];
    assign at_edge = up_down ? d == MAX : d == 4'd0;
    assign carry[i+1] = carry[i] & at_edge;
    assign stepped[4*i+:4] = !carry[i] ? d : at_edge ? (up_down ? 4'd0 : MAX) : up_down ? d + 4'd1 : d - 4'd1;
    assign load_fix[4*i+:4] = (DECIMAL && load_val[4*i+:4] > BCD_MAX) ? 4'd0 : load_val[4*i+:4];
    hex_seg_decoder u_seg (.digit(d), .seg(HEX[7*i+:7]));
  end
  always_ff @(posedge CLOCK_50 or posedge reset)
    if (reset) begin
      count <= '0;
      wrap  <= 1'b0;
    end else begin
      count <= load ? load_fix : tick ? stepped : count;
      wrap  <= ~load & tick & carry[DIGITS];
    end
endmodule

// File: tb/tb_multi_rate_counter.sv
// tb_multi_rate_counter: hex (4-digit) and BCD (2-digit) counters checked against an arithmetic model.
module tb_multi_rate_counter;
  logic clk = 1'b0, reset = 1'b1, enable = 1'b0, up_down = 1'b1, load = 1'b0;
  logic [1:0] rate_sel = 2'd0;
  logic [15:0] lv_h = '0, cnt_h;
  logic [7:0] lv_d = '0, cnt_d;
  logic tick_h, tick_d, wrap_h, wrap_d;
  logic [27:0] hex_h;
  logic [13:0] hex_d;
  int checks = 0, failures = 0;
  int m_div, m_rq, m_h, m_d;
  bit m_wh, m_wd, s_tick;
  localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  always #5 clk = ~clk;
  multi_rate_counter #(.DIGITS(4), .DECIMAL(1'b0), .DIV_W(28), .RATE0(28'd0), .RATE1(28'd3),
                       .RATE2(28'd5), .RATE3(28'd9)) u_hex (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .rate_sel(rate_sel), .up_down(up_down),
    .load(load), .load_val(lv_h), .count(cnt_h), .tick(tick_h), .wrap(wrap_h), .HEX(hex_h));
  multi_rate_counter #(.DIGITS(2), .DECIMAL(1'b1), .DIV_W(28), .RATE0(28'd0), .RATE1(28'd3),
                       .RATE2(28'd5), .RATE3(28'd9)) u_bcd (
    .CLOCK_50(clk), .reset(reset), .enable(enable), .rate_sel(rate_sel), .up_down(up_down),
    .load(load), .load_val(lv_d), .count(cnt_d), .tick(tick_d), .wrap(wrap_d), .HEX(hex_d));
  function automatic int rate_of(input int s);
    return s == 0 ? 0 : s == 1 ? 3 : s == 2 ? 5 : 9;
  endfunction
  function automatic int bcd_val(input logic [7:0] v);
    int hi = v[7:4] > 4'd9 ? 0 : int'(v[7:4]);
    int lo = v[3:0] > 4'd9 ? 0 : int'(v[3:0]);
    return hi * 10 + lo;
  endfunction
  function automatic logic [7:0] to_bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction
  function automatic logic [27:0] hex_of(input logic [15:0] v);
    logic [27:0] r;
    for (int i = 0; i < 4; i++) r[7*i+:7] = GLYPH[v[4*i+:4]];
    return r;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    m_div = 0; m_rq = 0; m_h = 0; m_d = 0; m_wh = 0; m_wd = 0;
  endtask
  task automatic step();
    logic [27:0] hx;
    @(negedge clk);
    s_tick = enable && m_div == 0 && int'(rate_sel) == m_rq;
    chk("tick_hex", tick_h, s_tick);
    chk("tick_bcd", tick_d, s_tick);
    if (enable) m_div = (int'(rate_sel) != m_rq || m_div == 0) ? rate_of(rate_sel) : m_div - 1;
    m_rq = rate_sel;
    m_wh = 0; m_wd = 0;
    if (load) begin
      m_h = lv_h;
      m_d = bcd_val(lv_d);
    end else if (s_tick) begin
      if (up_down) begin
        m_wh = m_h == 65535; m_h = (m_h + 1) % 65536;
        m_wd = m_d == 99;    m_d = (m_d + 1) % 100;
      end else begin
        m_wh = m_h == 0; m_h = (m_h + 65535) % 65536;
        m_wd = m_d == 0; m_d = (m_d + 99) % 100;
      end
    end
    @(posedge clk);
    #1;
    chk("count_hex", cnt_h, m_h);
    chk("wrap_hex", wrap_h, m_wh);
    chk("HEX_hex", hex_h, hex_of(16'(m_h)));
    hx = hex_of({8'h00, to_bcd(m_d)});
    chk("count_bcd", cnt_d, to_bcd(m_d));
    chk("wrap_bcd", wrap_d, m_wd);
    chk("HEX_bcd", hex_d, hx[13:0]);
  endtask
  typedef struct {
    logic en, ld, up;
    logic [15:0] lv;
    logic tk;
    logic [15:0] cnt;
    logic wr;
  } vec_t;
  vec_t tbl [14];
  logic [11:0] pat;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
  initial begin
    tbl[0]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0002, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b1, 16'hFFFF, 1'b1, 16'hFFFF, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0000, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0001, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0000, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'hFFFF, 1'b1};
    tbl[7]  = '{1'b0, 1'b1, 1'b1, 16'h1234, 1'b0, 16'h1234, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 16'h1234, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b1, 16'h1234, 1'b1, 16'h1234, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h1235, 1'b0};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h0F00, 1'b1, 16'h0F00, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b1, 16'h0EFF, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b1, 16'h0000, 1'b1, 16'h0F00, 1'b0};
    model_reset();
    enable = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_count", cnt_h, 0);
    chk("reset_wrap", wrap_h, 0);
    chk("reset_tick", tick_h, 0);
    chk("reset_HEX", hex_h, {4{7'h40}});
    reset = 1'b0;
    for (int i = 0; i < 14; i++) begin
      enable = tbl[i].en; load = tbl[i].ld; up_down = tbl[i].up; lv_h = tbl[i].lv;
      step();
      chk("tbl_tick", s_tick, tbl[i].tk);
      chk("tbl_count", cnt_h, tbl[i].cnt);
      chk("tbl_wrap", wrap_h, tbl[i].wr);
    end
    load = 1'b0;
    reset = 1'b1;
    model_reset();
    rate_sel = 2'd1; enable = 1'b1; up_down = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    pat = '0;
    for (int i = 1; i <= 12; i++) begin
      if (i == 11) rate_sel = 2'd0;
      step();
      pat[i-1] = s_tick;
    end
    chk("rate_pattern", pat, 12'h910);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rate0_every_cycle", s_tick, 1);
    end
    enable = 1'b0; load = 1'b1; lv_d = 8'h98;
    step();
    chk("bcd_load98", cnt_d, 8'h98);
    enable = 1'b1; load = 1'b0; up_down = 1'b1;
    step();
    chk("bcd_99", cnt_d, 8'h99);
    step();
    chk("bcd_up_roll", cnt_d, 8'h00);
    chk("bcd_up_wrap", wrap_d, 1);
    up_down = 1'b0;
    step();
    chk("bcd_down_roll", cnt_d, 8'h99);
    chk("bcd_down_wrap", wrap_d, 1);
    load = 1'b1; lv_d = 8'hA5;
    step();
    chk("bcd_loadA5", cnt_d, 8'h05);
    chk("bcd_load_nowrap", wrap_d, 0);
    enable = 1'b0;
    for (int n = 0; n < 16; n++) begin
      lv_h = {4{4'(n)}};
      step();
      for (int k = 0; k < 4; k++) chk("hex_glyph", hex_h[7*k+:7], GLYPH[n]);
    end
    enable = 1'b1; lv_h = 16'hABCD;
    step();
    load = 1'b0; up_down = 1'b1;
    step();
    @(posedge clk);
    #3 reset = 1'b1;
    #1;
    chk("async_count", cnt_h, 0);
    chk("async_HEX", hex_h, {4{7'h40}});
    chk("async_tick", tick_h, 0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    step();
    chk("first_tick_after_reset", s_tick, 1);
    chk("first_count_after_reset", cnt_h, 16'h0001);
    repeat (400) begin
      enable = $urandom_range(0, 9) != 0;
      if ($urandom_range(0, 19) == 0) rate_sel = 2'($urandom_range(0, 3));
      load = $urandom_range(0, 19) == 0;
      case ($urandom_range(0, 2))
        0: lv_h = 16'hFFFF;
        1: lv_h = 16'h0000;
        default: lv_h = 16'($urandom);
      endcase
      lv_d = 8'($urandom);
      up_down = 1'($urandom_range(0, 1));
      step();
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
